matrix_key_scan: RTL and testbench

Scans a 4x4 passive matrix keypad and emits a debounced 4-bit hex key code with a one-cycle valid strobe and a held level. It sits directly upstream of the hex 7-segment decoder: key_code feeds its 4-bit hex input and key_held can drive its dp input. It drives the columns active-low one at a time and reads the pulled-up rows, so no external logic is needed between keypad and FPGA pins.

---
 rtl/matrix_key_scan_pkg.sv | 24 ++
 rtl/matrix_key_decode.sv | 38 +++
 rtl/matrix_key_scan.sv | 196 +++++++++++++++++++
 tb/tb_matrix_key_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_key_scan_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: keypad geometry,
// debounce FSM states and the per-sweep classification.
package matrix_key_scan_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Debounce/acceptance FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } scan_state_e;

    // How many keys a completed sweep saw.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } sweep_class_e;

endpackage

// File: rtl/matrix_key_decode.sv
// Classifies one completed 16-key sweep snapshot as no key, exactly one key
// (with its code) or several keys. Purely combinational.
module matrix_key_decode
    import matrix_key_scan_pkg::*;
(
    input  logic [NUM_KEYS-1:0] snap_i,
    output sweep_class_e        cls_o,
    output logic [3:0]          code_o
);

    logic [4:0] ones;

    // Count set bits and keep the lowest set index (scan high to low so the
    // last hit wins).
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned and no latch is inferred.
        ones   = '0;
        code_o = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snap_i[i]) begin
                ones   = ones + 5'd1;
                code_o = 4'(i);
            end
        end
    end

    // Map the population count onto the three sweep classes.
    always_comb begin
        cls_o = CLS_MULTI;
        if (ones == 5'd0) begin
            cls_o = CLS_NONE;
        end else if (ones == 5'd1) begin
            cls_o = CLS_SINGLE;
        end
    end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 passive matrix keypad scanner. Drives one column low at a time, samples
// the pulled-up rows through a 2-FF synchronizer, builds a 16-bit snapshot
// per sweep and debounces whole sweeps into a hex key code, a one-cycle
// valid strobe and a held level.
module matrix_key_scan
    import matrix_key_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    // The counter holds the number of matching sweeps already seen, so the
    // sweep that makes it DEBOUNCE_SCANS arrives while it reads one less.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_SCANS - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    // Row synchronizer.
    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;

    // Column scan.
    logic [SLOT_W-1:0]   slot_q;
    logic [1:0]          col_q;
    logic [NUM_COLS-1:0] key_col_q;
    logic                slot_last;

    // Sweep snapshot.
    logic [NUM_KEYS-1:0] snap_q;
    logic [NUM_KEYS-1:0] snap_d;
    logic                sweep_done_q;

    // Sweep classification.
    sweep_class_e        sweep_cls;
    logic [3:0]          sweep_code;

    // Debounce FSM and registered outputs.
    scan_state_e         state_q;
    logic [3:0]          cand_q;
    logic [DEB_W-1:0]    deb_q;
    logic [3:0]          key_code_q;
    logic                key_valid_q;
    logic                key_held_q;

    assign slot_last = (slot_q == SLOT_LAST);

    // Two-stage synchronizer for the asynchronous keypad rows; idles at all
    // ones, matching released keys on pulled-up rows.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and the result is independent of block order.
        if (!sys_rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= key_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Slot counter and column rotation; the column advances on the same edge
    // that samples the rows for the column being left.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_q       <= '0;
            col_q        <= 2'd0;
            key_col_q    <= 4'b1110;
            sweep_done_q <= 1'b0;
        end else begin
            sweep_done_q <= slot_last && (col_q == 2'd3);
            if (slot_last) begin
                slot_q    <= '0;
                col_q     <= col_q + 2'd1;
                key_col_q <= {key_col_q[2:0], key_col_q[3]};
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end

    // Next snapshot: clear right after evaluation, otherwise fill in the
    // column being sampled (bit row*4+col set when that key is pressed).
    always_comb begin
        snap_d = snap_q;
        if (sweep_done_q) begin
            snap_d = '0;
        end else if (slot_last) begin
            snap_d[{2'd0, col_q}] = ~row_sync_q[0];
            snap_d[{2'd1, col_q}] = ~row_sync_q[1];
            snap_d[{2'd2, col_q}] = ~row_sync_q[2];
            snap_d[{2'd3, col_q}] = ~row_sync_q[3];
        end
    end

    // Snapshot register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    matrix_key_decode u_decode (
        .snap_i (snap_q),
        .cls_o  (sweep_cls),
        .code_o (sweep_code)
    );

    // Debounce FSM: advances once per completed sweep and owns the
    // registered key_code / key_valid / key_held outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            deb_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (sweep_done_q) begin
                case (state_q)
                    ST_IDLE: begin
                        if (sweep_cls == CLS_SINGLE) begin
                            cand_q  <= sweep_code;
                            deb_q   <= DEB_ONE;
                            state_q <= ST_PRESS_DEB;
                        end
                    end
                    ST_PRESS_DEB: begin
                        if (sweep_cls == CLS_SINGLE && sweep_code == cand_q) begin
                            if (deb_q == DEB_LAST) begin
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                deb_q       <= '0;
                                state_q     <= ST_HELD;
                            end else begin
                                deb_q <= deb_q + DEB_ONE;
                            end
                        end else if (sweep_cls == CLS_SINGLE) begin
                            cand_q <= sweep_code;
                            deb_q  <= DEB_ONE;
                        end else begin
                            deb_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        // Extra keys while held are ignored: no rollover.
                        if (sweep_cls == CLS_NONE) begin
                            deb_q   <= DEB_ONE;
                            state_q <= ST_REL_DEB;
                        end
                    end
                    ST_REL_DEB: begin
                        if (sweep_cls == CLS_NONE) begin
                            if (deb_q == DEB_LAST) begin
                                key_held_q <= 1'b0;
                                deb_q      <= '0;
                                state_q    <= ST_IDLE;
                            end else begin
                                deb_q <= deb_q + DEB_ONE;
                            end
                        end else begin
                            deb_q   <= '0;
                            state_q <= ST_HELD;
                        end
                    end
                    default: begin
                        deb_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign key_col   = key_col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Directed bench for matrix_key_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (16-cycle sweeps). A keypad model pulls a row low while its key is pressed
// and its column is driven low.
module tb_matrix_key_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int SWEEP          = 4 * SCAN_DIV;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed = '0;

    int n_checks  = 0;
    int n_errors  = 0;
    int valid_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    matrix_key_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Passive keypad: row r reads low when any pressed key in r sits on a
    // column currently driven low.
    always_comb begin
        key_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !key_col[c]) begin
                    key_row[r] = 1'b0;
                end
            end
        end
    end

    // Count every cycle key_valid is high; a stuck strobe shows up as extra.
    always @(negedge sys_clk) begin
        if (key_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_valid(input int max_cycles, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < max_cycles) begin
            @(negedge sys_clk);
            lat++;
            if (key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_held_low(input int max_cycles, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < max_cycles) begin
            @(negedge sys_clk);
            lat++;
            if (key_held === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic run_sweeps(input int n);
        repeat (n * SWEEP) @(negedge sys_clk);
    endtask

    initial begin
        logic [3:0] col_seq [4];
        int  lat;
        bit  seen;
        int  vc;

        col_seq[0] = 4'b1110;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111;

        // 1. Reset values, then free-running column rotation with no keys.
        repeat (3) @(negedge sys_clk);
        check("rst_key_col", key_col, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        sys_rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            repeat (SCAN_DIV) @(posedge sys_clk);
            @(negedge sys_clk);
            check($sformatf("col_rot_%0d", i), key_col, col_seq[i % 4]);
        end
        run_sweeps(3);
        check("idle_no_valid", valid_cnt, 0);
        check("idle_code", key_code, 4'h0);
        check("idle_held", key_held, 1'b0);

        // 2. Press row1/col2 (code 6) and hold.
        pressed = 16'h0040;
        wait_valid(6 * SWEEP, lat, seen);
        check("k6_seen", seen, 1'b1);
        check("k6_latency_le_67", lat <= (DEBOUNCE_SCANS + 1) * SWEEP + 3, 1'b1);
        check("k6_code", key_code, 4'h6);
        check("k6_held", key_held, 1'b1);
        @(negedge sys_clk);
        check("k6_pulse_one_cycle", key_valid, 1'b0);
        run_sweeps(3);
        check("k6_held_stays", key_held, 1'b1);
        check("k6_valid_count", valid_cnt, 1);
        pressed = '0;
        wait_held_low(6 * SWEEP, lat, seen);
        check("k6_release_seen", seen, 1'b1);
        check("k6_code_after_release", key_code, 4'h6);

        // 3. Bounce on key 0xA: single-sweep press, gap, press, release.
        vc = valid_cnt;
        pressed = 16'h0400;
        run_sweeps(1);
        pressed = '0;
        run_sweeps(1);
        pressed = 16'h0400;
        run_sweeps(1);
        pressed = '0;
        run_sweeps(5);
        check("bounce_no_valid", valid_cnt, vc);
        check("bounce_code_kept", key_code, 4'h6);
        check("bounce_held", key_held, 1'b0);

        // 4. Keys 3 and 12 together: multi-key sweeps never accepted.
        pressed = 16'h1008;
        run_sweeps(6);
        check("multi_no_valid", valid_cnt, vc);
        check("multi_held", key_held, 1'b0);
        pressed = '0;
        run_sweeps(4);
        check("multi_release_no_valid", valid_cnt, vc);

        // 5. Hold key 5, add key 9, release both, then press key 0xF.
        pressed = 16'h0020;
        wait_valid(6 * SWEEP, lat, seen);
        check("k5_seen", seen, 1'b1);
        check("k5_code", key_code, 4'h5);
        @(negedge sys_clk);
        check("k5_valid_count", valid_cnt, vc + 1);
        vc = valid_cnt;
        pressed = 16'h0220;
        run_sweeps(5);
        check("k5k9_no_retrigger", valid_cnt, vc);
        check("k5k9_code", key_code, 4'h5);
        check("k5k9_held", key_held, 1'b1);
        pressed = '0;
        wait_held_low(6 * SWEEP, lat, seen);
        check("k5_release_seen", seen, 1'b1);
        check("k5_release_min", lat >= 2 * SWEEP + 8, 1'b1);
        check("k5_release_max", lat <= (DEBOUNCE_SCANS + 1) * SWEEP + 3, 1'b1);
        check("k5_code_after_release", key_code, 4'h5);
        pressed = 16'h8000;
        wait_valid(6 * SWEEP, lat, seen);
        check("kf_seen", seen, 1'b1);
        check("kf_code", key_code, 4'hF);
        @(negedge sys_clk);
        check("kf_valid_count", valid_cnt, vc + 1);

        // 6. Asynchronous reset while held, released with the key still down.
        run_sweeps(1);
        check("kf_held_before_rst", key_held, 1'b1);
        vc = valid_cnt;
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_key_col", key_col, 4'b1110);
        check("async_rst_key_code", key_code, 4'h0);
        check("async_rst_key_valid", key_valid, 1'b0);
        check("async_rst_key_held", key_held, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_valid(5 * SWEEP, lat, seen);
        check("post_rst_seen", seen, 1'b1);
        check("post_rst_latency_min", lat >= DEBOUNCE_SCANS * SWEEP, 1'b1);
        check("post_rst_latency_max", lat <= DEBOUNCE_SCANS * SWEEP + 3, 1'b1);
        check("post_rst_code", key_code, 4'hF);
        run_sweeps(3);
        check("post_rst_one_valid", valid_cnt, vc + 1);
        check("post_rst_held", key_held, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
